// File: rtl/ffd_pkg.sv
// rtl/ffd_pkg.sv - shared state encodings and defaults for the ffd_piso_tx slice
package ffd_pkg;
  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SHIFT  = 2'b01,
    ST_PARITY = 2'b10
  } state_t;
endpackage

// File: rtl/piso_bit_cnt.sv
// rtl/piso_bit_cnt.sv - enable-gated bit counter with sync clear and terminal-count flag
module piso_bit_cnt #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  input  logic inc,
  output logic tc
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturates at LAST so the count never wraps even if inc lingers.
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (clr) begin
        cnt_d = '0;
      end else if (inc && (cnt_q != LAST)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == LAST);
endmodule

// File: rtl/ffd_piso_tx.sv
// rtl/ffd_piso_tx.sv - parallel-in/serial-out transmitter; FFD_PISO_PARITY_EN appends an even-parity bit
module ffd_piso_tx
  import ffd_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             accept;
  logic             tc;
  logic             head;
`ifdef FFD_PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign din_ready = (state_q == ST_IDLE) & en;
  assign accept    = din_valid & din_ready;
  assign head      = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

  piso_bit_cnt #(.WIDTH(WIDTH)) u_bit_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (accept | ((state_q == ST_SHIFT) & tc)),
    .inc   (state_q == ST_SHIFT),
    .tc    (tc)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
`ifdef FFD_PISO_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shreg_d = din;
          state_d = ST_SHIFT;
`ifdef FFD_PISO_PARITY_EN
          parity_d = ^din;
`endif
        end
      end
      ST_SHIFT: begin
        if (en) begin
          shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
          if (tc) begin
`ifdef FFD_PISO_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_IDLE;
`endif
          end
        end
      end
`ifdef FFD_PISO_PARITY_EN
      ST_PARITY: begin
        if (en) begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
`ifdef FFD_PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
`ifdef FFD_PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Outputs decode registered state only, so they freeze naturally with en.
  always_comb begin
    sout       = 1'b0;
    sout_valid = 1'b0;
    sout_last  = 1'b0;
    busy       = 1'b0;
    case (state_q)
      ST_SHIFT: begin
        sout       = head;
        sout_valid = 1'b1;
        busy       = 1'b1;
`ifndef FFD_PISO_PARITY_EN
        sout_last  = tc;
`endif
      end
`ifdef FFD_PISO_PARITY_EN
      ST_PARITY: begin
        sout       = parity_q;
        sout_valid = 1'b1;
        sout_last  = 1'b1;
        busy       = 1'b1;
      end
`endif
      default: ;
    endcase
  end
endmodule

// File: tb/tb_ffd_piso_tx.sv
// tb/tb_ffd_piso_tx.sv - self-checking bench for ffd_piso_tx (MSB-first and LSB-first instances)
module tb_ffd_piso_tx;
  localparam int W = 4;
`ifdef FFD_PISO_PARITY_EN
  localparam int FL     = W + 1;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int FL     = W;
  localparam bit PAR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b1;
  logic         din_valid = 1'b0;
  logic [W-1:0] din = '0;
  logic m_ready, m_sout, m_valid, m_last, m_busy;
  logic l_ready, l_sout, l_valid, l_last, l_busy;

  always #5 clk = ~clk;

  ffd_piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .en(en), .din_valid(din_valid), .din(din),
    .din_ready(m_ready), .sout(m_sout), .sout_valid(m_valid), .sout_last(m_last), .busy(m_busy)
  );

  ffd_piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .en(en), .din_valid(din_valid), .din(din),
    .din_ready(l_ready), .sout(l_sout), .sout_valid(l_valid), .sout_last(l_last), .busy(l_busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame model: one queue per instance holding the bits still to be sent.
  bit qm[$];
  bit ql[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      qm.delete();
      ql.delete();
    end else if (en) begin
      if (qm.size() > 0) void'(qm.pop_front());
      else if (din_valid) begin
        for (int i = 0; i < W; i++) qm.push_back(din[W-1-i]);
        if (PAR_EN) qm.push_back(^din);
      end
      if (ql.size() > 0) void'(ql.pop_front());
      else if (din_valid) begin
        for (int i = 0; i < W; i++) ql.push_back(din[i]);
        if (PAR_EN) ql.push_back(^din);
      end
    end
  end

  logic [31:0] cap_m, cap_l, lm_m, lm_l;
  int          ncap_m, ncap_l, nvh;
  bit          vh[0:63];

  task automatic clr_caps();
    cap_m = '0; cap_l = '0; lm_m = '0; lm_l = '0;
    ncap_m = 0; ncap_l = 0;
  endtask

  always @(negedge clk) begin
    chk("m_sout",  32'(m_sout),  32'((qm.size() > 0) ? qm[0] : 1'b0));
    chk("m_valid", 32'(m_valid), 32'(qm.size() > 0));
    chk("m_last",  32'(m_last),  32'(qm.size() == 1));
    chk("m_busy",  32'(m_busy),  32'(qm.size() > 0));
    chk("m_ready", 32'(m_ready), 32'((qm.size() == 0) && en));
    chk("l_sout",  32'(l_sout),  32'((ql.size() > 0) ? ql[0] : 1'b0));
    chk("l_valid", 32'(l_valid), 32'(ql.size() > 0));
    chk("l_last",  32'(l_last),  32'(ql.size() == 1));
    chk("l_busy",  32'(l_busy),  32'(ql.size() > 0));
    chk("l_ready", 32'(l_ready), 32'((ql.size() == 0) && en));
    if (!reset && en) begin
      if (m_valid) begin
        cap_m = {cap_m[30:0], m_sout}; lm_m = {lm_m[30:0], m_last}; ncap_m++;
      end
      if (l_valid) begin
        cap_l = {cap_l[30:0], l_sout}; lm_l = {lm_l[30:0], l_last}; ncap_l++;
      end
      if (nvh < 64) vh[nvh] = m_valid;
      nvh++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] w);
    din = w; din_valid = 1'b1;
    step(1);
    din_valid = 1'b0;
  endtask

  // Hand-written frame in transmit order, with the hand-computed parity bit when enabled.
  function automatic logic [31:0] fr(input logic [3:0] b, input logic p);
    fr = PAR_EN ? {27'b0, b, p} : {28'b0, b};
  endfunction

  logic [31:0] got, want;

  initial begin
    clr_caps();
    nvh = 0;
    step(2);
    chk("rst_sout", 32'(m_sout), 0);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_last", 32'(m_last), 0);
    chk("rst_busy", 32'(m_busy), 0);
    reset = 1'b0;
    step(1);

    // 1: MSB-first 1011
    clr_caps();
    send(4'b1011);
    chk("t1_bit0", 32'(m_sout), 1);
    chk("t1_valid0", 32'(m_valid), 1);
    step(3);
    chk("t1_last_c4", 32'(m_last), 32'(!PAR_EN));
    step(1 + FL - W);
    chk("t1_ready_after", 32'(m_ready), 1);
    step(2);
    chk("t1_m_bits", cap_m, fr(4'b1011, 1'b1));
    chk("t1_m_lastmask", lm_m, 1);
    chk("t1_l_bits", cap_l, fr(4'b1101, 1'b1));

    // 2: LSB-first 0001
    clr_caps();
    send(4'b0001);
    step(FL + 2);
    chk("t2_l_bits", cap_l, fr(4'b1000, 1'b1));
    chk("t2_l_nvalid", 32'(ncap_l), 32'(FL));
    chk("t2_l_lastmask", lm_l, 1);

    // 3: en low for two cycles mid-frame
    clr_caps();
    send(4'b1010);
    step(1);
    en = 1'b0;
    step(2);
    chk("t3_hold_sout", 32'(m_sout), 0);
    chk("t3_hold_valid", 32'(m_valid), 1);
    chk("t3_hold_ready", 32'(m_ready), 0);
    chk("t3_hold_busy", 32'(m_busy), 1);
    en = 1'b1;
    step(FL + 2);
    chk("t3_m_bits", cap_m, fr(4'b1010, 1'b0));
    chk("t3_m_nvalid", 32'(ncap_m), 32'(FL));
    chk("t3_l_bits", cap_l, fr(4'b0101, 1'b0));

    // 4: reset mid-frame, then a clean word
    send(4'b1111);
    step(1);
    reset = 1'b1;
    #1;
    chk("t4_rst_valid", 32'(m_valid), 0);
    chk("t4_rst_busy", 32'(m_busy), 0);
    chk("t4_rst_sout", 32'(m_sout), 0);
    chk("t4_rst_l_valid", 32'(l_valid), 0);
    #2;
    reset = 1'b0;
    step(1);
    clr_caps();
    send(4'b1100);
    step(FL + 2);
    chk("t4_m_bits", cap_m, fr(4'b1100, 1'b0));

    // 5: 0111 (parity 1 appended when enabled)
    clr_caps();
    send(4'b0111);
    step(FL + 2);
    chk("t5_m_bits", cap_m, fr(4'b0111, 1'b1));
    chk("t5_m_lastmask", lm_m, 1);

    // 6: back-to-back words with din_valid held high
    clr_caps();
    din = 4'b1001; din_valid = 1'b1;
    step(1);
    din = 4'b0110;
    nvh = 0;
    for (int i = 0; i < 4 * FL && !m_ready; i++) step(1);
    chk("t6_ready_seen", 32'(m_ready), 1);
    step(1);
    din_valid = 1'b0;
    step(FL + 2);
    got = '0;
    for (int i = 0; i < 2 * FL + 2; i++) got = {got[30:0], vh[i]};
    want = (((32'd1 << FL) - 1) << (FL + 2)) | (((32'd1 << FL) - 1) << 1);
    chk("t6_valid_gap", got, want);
    chk("t6_m_bits", cap_m, (fr(4'b1001, 1'b0) << FL) | fr(4'b0110, 1'b0));
    chk("t6_m_lastmask", lm_m, (32'd1 << FL) | 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
